mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares a single 4-to-1 data mux among four requesters.
- Grants one requester at a time and drives the mux select.
- Forwards the selected requester's data downstream through a valid/ready handshake.
- Holds each grant for a bounded burst of beats, then rotates priority.

Parameters:
- WIDTH, 8: data width per requester, in bits.
- MAX_BURST, 4: maximum accepted beats per grant; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  per-requester request; req[i] high means in_data slice i is valid.
- in_data  input  4*WIDTH  requester data; slice i = in_data[i*WIDTH +: WIDTH].
- in_ready  output  4  per-requester accept; in_ready[i] = gnt[i] & out_ready & req[i].
- out_data  output  WIDTH  muxed data = slice selected by sel.
- out_valid  output  1  downstream valid.
- out_ready  input  1  downstream ready.
- sel  output  2  registered mux select (binary index of the granted requester).
- gnt  output  4  registered one-hot grant; all zero when idle.
- busy  output  1  high while in the GRANT state.

Behaviour:
- Reset, asynchronous: state=IDLE, sel=2'b00, gnt=4'b0000, busy=0, beat_cnt=0.
- Reset also sets the priority pointer last=3, so requester 0 has top priority after reset.
- out_valid=0 and in_ready=0 during and after reset until a grant exists.
- States: IDLE and GRANT.
- Arbitration function: scan indices last+1, last+2, last+3, last (mod 4) and pick the first i with req[i]=1.
- IDLE:
  - if req != 0, register sel=i, gnt=1<<i, last=i, beat_cnt=0, and go to GRANT.
  - otherwise stay in IDLE.
  - Latency: req asserted at edge N gives gnt/out_valid visible after edge N+1 (one cycle).
- GRANT:
  - out_valid = req[sel] (combinational).
  - out_data = in_data slice sel (combinational).
  - Transfer = out_valid & out_ready; on transfer, beat_cnt increments.
- Release in GRANT:
  - Release when req[sel]=0 (no transfer that cycle), or when a transfer occurs with beat_cnt == MAX_BURST-1.
  - On release, re-arbitrate in the same cycle using the current req vector, with pointer = sel.
  - If any request exists, load the new sel/gnt (beat_cnt=0) and stay in GRANT, with no bubble cycle.
  - Otherwise go to IDLE, set gnt=0, and keep sel at its last value.
- If the granted requester is the only one requesting at burst end, it is re-granted (pointer wraps to itself) with beat_cnt=0.
- out_ready held low: the grant is held indefinitely, beat_cnt does not advance, and there is no timeout.
- Requests arriving mid-burst from other requesters wait for release; they do not pre-empt.
- Reset asserted mid-burst: immediate return to reset values. The partially transferred burst is abandoned; the bench must not expect completion.
- beat_cnt width: clog2(MAX_BURST+1) bits; it never exceeds MAX_BURST-1.
- gnt is always one-hot or zero, and sel is always consistent with gnt when gnt != 0.

Optional Feature:
- MUX_ARB_FIXED_PRIO_EN defined:
  - The arbitration scan always starts at index 0 (req0 highest, req3 lowest); the pointer is ignored.
  - Burst limit and release rules are unchanged, so a continuous req0 starves the others.
- Undefined: round-robin as described above.

Test Plan:
1. Reset, then req=4'b0001 with out_ready=1 for 6 cycles -> gnt=0001 and sel=00 one cycle after req. Four beats transfer, then re-grant to requester 0 with beat_cnt=0, giving one continuous stream.
2. req=4'b1111, out_ready=1, in_data slices 0xA0, 0xB1, 0xC2, 0xD3 -> grant order 0,1,2,3,0. Each grant carries exactly 4 beats with out_data matching the slice, and there are no idle cycles between grants.
3. req=4'b0110, out_ready=0 for 10 cycles, then 1 -> gnt=0010 held throughout with beat_cnt=0. After out_ready rises, 4 beats go to requester 1, then gnt=0100.
4. Granted requester 2 drops req after 2 beats while req3=1 -> gnt moves to 1000 the next cycle. Requester 2's two beats are the only ones accepted from it.
5. Assert rst mid-burst (beat 2 of requester 1) -> gnt=0000, sel=00, out_valid=0 immediately. After release with req=4'b1111, requester 0 is granted first.
6. With MUX_ARB_FIXED_PRIO_EN and req=4'b1011 -> grant order 0,0,0,... while req0 stays high. Drop req0 -> grants go to 1, then back to 0 when req0 returns.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux among four requesters, with bounded bursts.
// Define MUX_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (req0 highest).
module mux4_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         sel,
  output logic [3:0]         gnt,
  output logic               busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] beat_cnt;

  logic [1:0] idle_ptr;
  logic [1:0] rel_ptr;
  logic [2:0] idle_pick;
  logic [2:0] rel_pick;
  logic       xfer;
  logic       release_now;
  logic       load;
  logic [1:0] load_idx;

  // Returns {found, index}: first requester after ptr, wrapping around to ptr itself.
  function automatic logic [2:0] arbitrate(input logic [3:0] r, input logic [1:0] ptr);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (r[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

`ifdef MUX_ARB_FIXED_PRIO_EN
  // A constant pointer of 3 makes every scan start at requester 0.
  assign idle_ptr = 2'd3;
  assign rel_ptr  = 2'd3;
`else
  logic [1:0] last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 2'd3;
    end else if (load) begin
      last <= load_idx;
    end
  end

  assign idle_ptr = last;
  assign rel_ptr  = sel;
`endif

  assign idle_pick = arbitrate(req, idle_ptr);
  assign rel_pick  = arbitrate(req, rel_ptr);

  assign busy      = (state == GRANT);
  assign out_valid = busy & req[sel];
  assign out_data  = in_data[int'(sel)*WIDTH +: WIDTH];
  assign in_ready  = gnt & {4{out_ready}} & req;

  assign xfer        = out_valid & out_ready;
  assign release_now = busy & (~req[sel] | (xfer & (beat_cnt == LAST_BEAT)));

  // Re-arbitration on release happens in the same cycle, so back-to-back grants have no bubble.
  assign load     = ((state == IDLE) & idle_pick[2]) | (release_now & rel_pick[2]);
  assign load_idx = busy ? rel_pick[1:0] : idle_pick[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 2'b00;
      gnt      <= 4'b0000;
      beat_cnt <= '0;
    end else begin
      if (load) begin
        state    <= GRANT;
        sel      <= load_idx;
        gnt      <= 4'b0001 << load_idx;
        beat_cnt <= '0;
      end else if (release_now) begin
        // sel keeps its last value while idle
        state    <= IDLE;
        gnt      <= 4'b0000;
        beat_cnt <= '0;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule
